// File: rtl/ram_scan_reader_pkg.sv
// ----------------------------------------------------------------------------
// ram_scan_reader_pkg
//   Shared definitions for the RAM scan reader: default address/data widths,
//   the width of the RAM-side address bus, and the scan FSM state encoding.
// ----------------------------------------------------------------------------
package ram_scan_reader_pkg;

    localparam int unsigned ADDR_W_DEF = 6;   // 64-word RAM
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RAM_ADDR_W = 32;  // width of the ram_addr port

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_PRESENT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ram_scan_reader.sv
// ----------------------------------------------------------------------------
// ram_scan_reader
//   Reads `count` consecutive words from a synchronous RAM starting at
//   `base_addr` (address wraps modulo the RAM depth) and hands each word to a
//   consumer over a valid/ready interface, one outstanding read at a time.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle scan request (ignored while busy)
//   abort               synchronous cancel of a running scan
//   base_addr, count    scan start address and length (0..2^ADDR_W, clamped)
//   ram_addr/ram_en     RAM read request, ram_en high one cycle per read
//   ram_we              RAM write enable, tied low
//   ram_dout            RAM read data, valid RAM_LAT cycles after the request
//   out_data/out_valid  word offered to the consumer
//   out_ready           consumer accepts the word
//   busy                scan in progress
//   done                one-cycle pulse on normal completion
// ----------------------------------------------------------------------------
module ram_scan_reader
    import ram_scan_reader_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       count,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  ram_en,
    input  logic [DATA_W-1:0]     ram_dout,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]      WAIT_INIT = 3'(RAM_LAT - 1);

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [2:0]          wait_cnt_q,  wait_cnt_d;
    logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
    logic                ram_en_q,    ram_en_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    logic [ADDR_W-1:0]   addr_next;

    assign addr_next = addr_q + 1'b1;   // natural wrap modulo 2^ADDR_W

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_en_d    = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // Outputs are registered, so each state's outputs are set up on the
        // transition into it (e.g. ram_en is raised when entering READ).
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (count == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d      = base_addr;
                        remaining_d = (count > MAX_COUNT) ? MAX_COUNT : count;
                        ram_addr_d  = base_addr;
                        ram_en_d    = 1'b1;
                        state_d     = ST_READ;
                    end
                end
            end
            ST_READ: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    out_data_d  = ram_dout;
                    out_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_PRESENT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d     = addr_next;
                        ram_addr_d = addr_next;
                        ram_en_d   = 1'b1;
                        state_d    = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the state logic decided this cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            ram_en_d    = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            ram_addr_q  <= '0;
            ram_en_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_en_q    <= ram_en_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ram_addr  = RAM_ADDR_W'(ram_addr_q);
    assign ram_we    = 1'b0;
    assign ram_en    = ram_en_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// ----------------------------------------------------------------------------
// tb_ram_scan_reader
//   Directed bench for ram_scan_reader with a 1-cycle-latency RAM model
//   preloaded with mem[k] = k + 0x100.
// ----------------------------------------------------------------------------
module tb_ram_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [6:0]  count = '0;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic        ram_en;
    logic [31:0] ram_dout = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] mem [64];
    logic [31:0] data_log [$];
    logic [31:0] addr_log [$];
    int          en_cnt = 0;
    int          done_cnt = 0;
    bit          valid_seen = 0;
    bit          viol = 0;

    ram_scan_reader #(
        .ADDR_W (6),
        .DATA_W (32),
        .RAM_LAT(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .base_addr(base_addr),
        .count    (count),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_en   (ram_en),
        .ram_dout (ram_dout),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, read latency 1
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr[5:0]];
    end

    // Activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (ram_en) begin
            en_cnt++;
            addr_log.push_back(ram_addr);
        end
        if (done) done_cnt++;
        if (out_valid) valid_seen = 1;
        if (out_valid && out_ready && !abort) data_log.push_back(out_data);
        if (out_valid && done) viol = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        data_log.delete();
        addr_log.delete();
        en_cnt = 0;
        done_cnt = 0;
        valid_seen = 0;
    endtask

    task automatic start_scan(input logic [5:0] b, input logic [6:0] c);
        base_addr = b;
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycles counted from the edge that sampled start (that edge is cycle 1).
    task automatic wait_done(output int cyc, output bit ok);
        cyc = 1;
        ok = done;
        while (!ok && cyc < 400) begin
            tick();
            cyc++;
            if (done) ok = 1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (out_valid) ok = 1;
            else tick();
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        compared++; if (ram_addr !== 32'h0) begin mismatched++; $display("FAIL reset_ram_addr: got %0h expected 0", ram_addr); end
        compared++; if (ram_en !== 1'b0) begin mismatched++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
        compared++; if (ram_we !== 1'b0) begin mismatched++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        compared++; if (out_data !== 32'h0) begin mismatched++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", done); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc; bit ok;
        clear_logs();
        out_ready = 1'b1;
        start_scan(6'd5, 7'd3);
        wait_done(cyc, ok);
        tick();
        compared++; if (!ok) begin mismatched++; $display("FAIL basic_timeout: no done within %0d cycles", cyc); end
        compared++; if (cyc !== 10) begin mismatched++; $display("FAIL basic_latency: got %0d cycles expected 10", cyc); end
        compared++; if (data_log.size() !== 3) begin mismatched++; $display("FAIL basic_words: got %0d expected 3", data_log.size()); end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (i >= data_log.size() || data_log[i] !== 32'h105 + 32'(i)) begin
                mismatched++; $display("FAIL basic_data[%0d]: got %0h expected %0h", i, (i < data_log.size()) ? data_log[i] : 32'hx, 32'h105 + 32'(i));
            end
        end
        compared++; if (en_cnt !== 3) begin mismatched++; $display("FAIL basic_ram_en: got %0d expected 3", en_cnt); end
        compared++; if (done_cnt !== 1) begin mismatched++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_wrap();
        int cyc; bit ok;
        int exp_a [4] = '{62, 63, 0, 1};
        clear_logs();
        out_ready = 1'b1;
        start_scan(6'd62, 7'd4);
        wait_done(cyc, ok);
        tick();
        compared++; if (!ok) begin mismatched++; $display("FAIL wrap_timeout: no done within %0d cycles", cyc); end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (i >= addr_log.size() || addr_log[i] !== 32'(exp_a[i])) begin
                mismatched++; $display("FAIL wrap_addr[%0d]: got %0h expected %0h", i, (i < addr_log.size()) ? addr_log[i] : 32'hx, exp_a[i]);
            end
            compared++;
            if (i >= data_log.size() || data_log[i] !== 32'h100 + 32'(exp_a[i])) begin
                mismatched++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", i, (i < data_log.size()) ? data_log[i] : 32'hx, 32'h100 + 32'(exp_a[i]));
            end
        end
        compared++; if (en_cnt !== 4) begin mismatched++; $display("FAIL wrap_ram_en: got %0d expected 4", en_cnt); end
    endtask

    task automatic test_backpressure();
        int cyc; bit ok; bit stable;
        clear_logs();
        out_ready = 1'b0;
        start_scan(6'd20, 7'd2);
        wait_valid(ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL bp_valid_timeout: out_valid never rose"); end
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 32'h114) stable = 0;
        end
        compared++; if (stable !== 1'b1) begin mismatched++; $display("FAIL bp_stable: got valid=%b data=%0h expected 1/114", out_valid, out_data); end
        compared++; if (en_cnt !== 1) begin mismatched++; $display("FAIL bp_no_extra_read: got %0d expected 1", en_cnt); end
        out_ready = 1'b1;
        wait_done(cyc, ok);
        tick();
        compared++; if (!ok) begin mismatched++; $display("FAIL bp_done_timeout: no done"); end
        compared++; if (data_log.size() !== 2) begin mismatched++; $display("FAIL bp_words: got %0d expected 2", data_log.size()); end
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (i >= data_log.size() || data_log[i] !== 32'h114 + 32'(i)) begin
                mismatched++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, (i < data_log.size()) ? data_log[i] : 32'hx, 32'h114 + 32'(i));
            end
        end
        compared++; if (en_cnt !== 2) begin mismatched++; $display("FAIL bp_ram_en: got %0d expected 2", en_cnt); end
    endtask

    task automatic test_count_zero();
        clear_logs();
        out_ready = 1'b1;
        start_scan(6'd9, 7'd0);
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL zero_done: got %b expected 1", done); end
        tick();
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL zero_done_width: got %b expected 0", done); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL zero_busy: got %b expected 0", busy); end
        tick();
        compared++; if (en_cnt !== 0) begin mismatched++; $display("FAIL zero_ram_en: got %0d expected 0", en_cnt); end
        compared++; if (valid_seen !== 1'b0) begin mismatched++; $display("FAIL zero_valid: got %b expected 0", valid_seen); end
        compared++; if (done_cnt !== 1) begin mismatched++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_count_full();
        int cyc; bit ok;
        int bases [2] = '{0, 10};
        logic [6:0] counts [2] = '{7'd64, 7'd100};
        for (int t = 0; t < 2; t++) begin
            clear_logs();
            out_ready = 1'b1;
            start_scan(6'(bases[t]), counts[t]);
            wait_done(cyc, ok);
            tick();
            compared++; if (!ok || cyc !== 193) begin mismatched++; $display("FAIL full%0d_latency: got %0d cycles (ok=%b) expected 193", t, cyc, ok); end
            compared++; if (en_cnt !== 64) begin mismatched++; $display("FAIL full%0d_ram_en: got %0d expected 64", t, en_cnt); end
            compared++; if (data_log.size() !== 64) begin mismatched++; $display("FAIL full%0d_words: got %0d expected 64", t, data_log.size()); end
            for (int i = 0; i < 64; i++) begin
                compared++;
                if (i >= addr_log.size() || addr_log[i] !== 32'((bases[t] + i) % 64)) begin
                    mismatched++; $display("FAIL full%0d_addr[%0d]: got %0h expected %0h", t, i, (i < addr_log.size()) ? addr_log[i] : 32'hx, (bases[t] + i) % 64);
                end
                compared++;
                if (i >= data_log.size() || data_log[i] !== 32'h100 + 32'((bases[t] + i) % 64)) begin
                    mismatched++; $display("FAIL full%0d_data[%0d]: got %0h expected %0h", t, i, (i < data_log.size()) ? data_log[i] : 32'hx, 32'h100 + 32'((bases[t] + i) % 64));
                end
            end
            compared++; if (done_cnt !== 1) begin mismatched++; $display("FAIL full%0d_done_pulses: got %0d expected 1", t, done_cnt); end
        end
    endtask

    task automatic test_abort();
        int cyc; bit ok;
        clear_logs();
        out_ready = 1'b0;
        start_scan(6'd0, 7'd8);
        for (int w = 0; w < 2; w++) begin
            wait_valid(ok);
            compared++; if (!ok) begin mismatched++; $display("FAIL abort_valid%0d_timeout: out_valid never rose", w); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        wait_valid(ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL abort_valid2_timeout: out_valid never rose"); end
        abort = 1'b1;
        out_ready = 1'b1;
        base_addr = 6'd33;
        count = 7'd5;
        start = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        start = 1'b0;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b expected 0", busy); end
        compared++; if (ram_en !== 1'b0) begin mismatched++; $display("FAIL abort_ram_en: got %b expected 0", ram_en); end
        for (int i = 0; i < 5; i++) tick();
        compared++; if (done_cnt !== 0) begin mismatched++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
        compared++; if (en_cnt !== 3) begin mismatched++; $display("FAIL abort_ram_en_cnt: got %0d expected 3", en_cnt); end
        compared++; if (data_log.size() !== 2) begin mismatched++; $display("FAIL abort_words: got %0d expected 2", data_log.size()); end
        clear_logs();
        out_ready = 1'b1;
        start_scan(6'h10, 7'd1);
        wait_done(cyc, ok);
        tick();
        compared++; if (!ok) begin mismatched++; $display("FAIL abort_restart_timeout: no done"); end
        compared++; if (data_log.size() !== 1 || data_log[0] !== 32'h110) begin mismatched++; $display("FAIL abort_restart_data: got %0h (n=%0d) expected 110", (data_log.size() > 0) ? data_log[0] : 32'hx, data_log.size()); end
        compared++; if (done_cnt !== 1) begin mismatched++; $display("FAIL abort_restart_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_midscan();
        int cyc; bit ok;
        clear_logs();
        out_ready = 1'b1;
        start_scan(6'd30, 7'd4);
        base_addr = 6'd0;
        count = 7'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        compared++; if (ram_addr !== 32'd31) begin mismatched++; $display("FAIL midscan_addr: got %0h expected 1f", ram_addr); end
        compared++; if (data_log.size() !== 1 || data_log[0] !== 32'h11E) begin mismatched++; $display("FAIL midscan_first_word: got %0h (n=%0d) expected 11e", (data_log.size() > 0) ? data_log[0] : 32'hx, data_log.size()); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL midscan_busy: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        compared++; if (ram_addr !== 32'h0) begin mismatched++; $display("FAIL rst_mid_ram_addr: got %0h expected 0", ram_addr); end
        compared++; if (ram_en !== 1'b0) begin mismatched++; $display("FAIL rst_mid_ram_en: got %b expected 0", ram_en); end
        compared++; if (out_data !== 32'h0) begin mismatched++; $display("FAIL rst_mid_out_data: got %0h expected 0", out_data); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        tick(); tick();
        rst_n = 1'b1;
        start_scan(6'd7, 7'd1);
        wait_done(cyc, ok);
        tick();
        compared++; if (!ok || cyc !== 4) begin mismatched++; $display("FAIL rst_restart_latency: got %0d cycles (ok=%b) expected 4", cyc, ok); end
        compared++; if (en_cnt !== 3) begin mismatched++; $display("FAIL rst_ram_en_cnt: got %0d expected 3", en_cnt); end
        compared++; if (data_log.size() !== 2 || data_log[1] !== 32'h107) begin mismatched++; $display("FAIL rst_restart_data: got n=%0d expected 2 words ending 107", data_log.size()); end
        compared++; if (done_cnt !== 1) begin mismatched++; $display("FAIL rst_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h100 + 32'(k);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_count_zero();
        test_count_full();
        test_abort();
        test_reset_midscan();
        compared++; if (viol !== 1'b0) begin mismatched++; $display("FAIL done_with_valid: got %b expected 0", viol); end
        compared++; if (ram_we !== 1'b0) begin mismatched++; $display("FAIL ram_we_const: got %b expected 0", ram_we); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_scan_reader.md
RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
REQ-001 The parameters SHALL be, one per line:
- ADDR_W, 6, RAM word-address width (64 words).
- DATA_W, 32, RAM data width.
- RAM_LAT, 1, RAM read latency in clock cycles, counted from the address being registered; legal range 1..4.

REQ-002 The ports SHALL be, one per line:
- clk  in  1  single clock, rising edge; all state on this edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a scan.
- abort  in  1  synchronous cancel of a running scan.
- base_addr  in  ADDR_W  first word address of the scan.
- count  in  ADDR_W+1  number of words to read, 0..64.
- ram_addr  out  32  word address to RAM; bits above ADDR_W are always 0.
- ram_we  out  1  RAM write enable; constant 0.
- ram_en  out  1  read strobe; high one cycle per issued read.
- ram_dout  in  DATA_W  RAM read data.
- out_data  out  DATA_W  word presented to the consumer.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a scan completes normally.

Function
REQ-003 The FSM SHALL have the states IDLE, READ, WAIT, PRESENT and DONE; all outputs SHALL be registered.
REQ-004 In IDLE, start=1 with count!=0 SHALL latch addr=base_addr and remaining=count, set busy=1 on the next cycle and enter READ.
REQ-005 In IDLE, start=1 with count=0 SHALL enter DONE directly, with no RAM access and no out_valid.
REQ-006 In READ, the block SHALL drive ram_addr=addr and ram_en=1 for exactly one cycle, then enter WAIT.
REQ-007 WAIT SHALL last RAM_LAT cycles; on its last cycle, ram_dout SHALL be captured into out_data, with out_valid=1 from the next cycle, and the FSM SHALL enter PRESENT.
REQ-008 In PRESENT, out_data and out_valid SHALL stay stable until out_valid&&out_ready is sampled high.
REQ-009 On that handshake, remaining SHALL decrement and out_valid SHALL clear on the next cycle.
REQ-010 After the handshake, the FSM SHALL enter DONE if remaining was 1; otherwise it SHALL set addr=(addr+1) mod 2^ADDR_W and enter READ.
REQ-011 Address arithmetic SHALL wrap: base_addr=62 with count=4 reads 62, 63, 0, 1.
REQ-012 In DONE, done=1 for one cycle, then busy=0 and return to IDLE; done and busy SHALL never both be high while out_valid=1.
REQ-013 start asserted while busy=1 SHALL be ignored, with no effect on addr, remaining or outputs.
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle with out_valid=0, busy=0, ram_en=0 and no done pulse; abort has priority over out_ready and start in the same cycle.
REQ-015 count=64 SHALL read all 64 words exactly once; count values above 64 SHALL be treated as 64.
REQ-016 Minimum throughput with out_ready held high SHALL be one word per RAM_LAT+2 cycles.

Reset
REQ-017 rst_n=0 SHALL immediately force IDLE, with ram_addr=0, ram_en=0, ram_we=0, out_data=0, out_valid=0, busy=0, done=0, addr=0 and remaining=0.
REQ-018 Reset asserted mid-scan SHALL discard the scan; after release the block SHALL wait for a new start.
REQ-019 Reset deassertion is synchronised externally; the block SHALL require no extra cycles after release.

Structure
REQ-020 A shared package SHALL hold the state enumeration, ADDR_W and DATA_W defaults, and the 32-bit RAM address width constant.
REQ-021 The block SHALL be a single module with no sub-modules; the RAM is instantiated beside it in the top level.

Verification
REQ-022 With RAM preloaded with mem[k]=k+0x100, base=5, count=3 and out_ready=1, the bench SHALL see out_data 0x105, 0x106, 0x107, then one done pulse, with ram_en high exactly 3 times.
REQ-023 With base=62, count=4, the bench SHALL see ram_addr sequence 62, 63, 0, 1 and data mem[62], mem[63], mem[0], mem[1].
REQ-024 With out_ready held 0 for 10 cycles in PRESENT, the bench SHALL see out_valid and out_data held stable and no further ram_en; raising out_ready SHALL resume the scan.
REQ-025 With start and count=0, the bench SHALL see done one cycle later, out_valid never high and ram_en never high.
REQ-026 Abort scenario, base=0, count=8:
- Abort during the 3rd word's PRESENT SHALL give out_valid=0 next cycle and no done.
- A new start with base=0x10, count=1 SHALL then return mem[0x10].
REQ-027 Reset scenario: rst_n pulsed low mid-WAIT SHALL zero all outputs asynchronously, and a start issued during the scan SHALL be shown to have no effect.
